alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the datapath ALU for the multi-cycle MIPS core. It executes single-cycle logic/arithmetic ops and, optionally, iterative unsigned multiply and divide behind a start/done handshake. The control FSM of the core stalls on `busy`. Results and the `zero` flag are registered, and they hold stable until the next accepted operation.

---
 rtl/alu_mc.sv | 204 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus optional iterative unsigned MULU/DIVU.
// Latency: 1 cycle for simple ops and DIVU by zero; WIDTH+1 cycles for MULU/DIVU.
// Backpressure: no queueing; start is only sampled in IDLE, busy is high while iterating.
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, alufn    : operation request and 4-bit opcode, captured together in IDLE
//   ra, rb_or_imm   : operands A and B, captured with start
//   aluout, hi      : result low word / high word (product high or remainder), registered
//   zero            : (aluout == 0), registered with aluout
//   busy, done      : busy in RUN; done is a one-cycle pulse when results are valid
//
// Build option: define ALU_MC_MULDIV_EN to build the MULU/DIVU iteration datapath.
// Without it, opcodes 8/9 finish in one cycle with aluout = 0, hi = 0 and busy is tied low.

module alu_mc #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alufn,
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] rb_or_imm,
   output logic [WIDTH-1:0] aluout,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_MULU = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic             accept;
   logic             long_op;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;

   assign accept = (state == S_IDLE) && start;

   // Result of every op that completes straight from IDLE (including DIVU by zero).
   always_comb begin
      res_lo = ra + rb_or_imm;
      res_hi = '0;
      case (alufn)
         OP_ADD:  res_lo = ra + rb_or_imm;
         OP_SUB:  res_lo = ra - rb_or_imm;
         OP_AND:  res_lo = ra & rb_or_imm;
         OP_OR:   res_lo = ra | rb_or_imm;
         OP_XOR:  res_lo = ra ^ rb_or_imm;
         OP_SLT:  res_lo = {{(WIDTH-1){1'b0}}, ($signed(ra) < $signed(rb_or_imm))};
         OP_SLTU: res_lo = {{(WIDTH-1){1'b0}}, (ra < rb_or_imm)};
         OP_NOR:  res_lo = ~(ra | rb_or_imm);
         OP_MULU: res_lo = '0;
         OP_DIVU: begin
`ifdef ALU_MC_MULDIV_EN
            // Only reached as a one-cycle op when the divisor is zero.
            res_lo = '1;
            res_hi = ra;
`else
            res_lo = '0;
`endif
         end
         default: res_lo = ra + rb_or_imm;   // reserved opcodes alias ADD
      endcase
   end

`ifdef ALU_MC_MULDIV_EN
   // Iteration state. acc is the product high half / partial remainder;
   // mq is the multiplier (shifted out as product low bits) / dividend (shifted
   // out as quotient bits); opd is the multiplicand or the divisor.
   logic             is_mul;
   logic [WIDTH-1:0] opd;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] mq_nxt;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             run_last;

   assign long_op  = (alufn == OP_MULU) || ((alufn == OP_DIVU) && (rb_or_imm != '0));
   assign run_last = (state == S_RUN) && (cnt == CW'(1));

   always_comb begin
      acc_nxt   = acc;
      mq_nxt    = mq;
      mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      div_shift = {acc, mq[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opd};
      if (is_mul) begin
         // Shift-add: add multiplicand on a 1 bit, then shift {acc, mq} right.
         acc_nxt = mul_sum[WIDTH:1];
         mq_nxt  = {mul_sum[0], mq[WIDTH-1:1]};
      end else if (div_diff[WIDTH]) begin
         // Borrow out: divisor does not fit, restore and shift in a 0.
         acc_nxt = div_shift[WIDTH-1:0];
         mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = div_diff[WIDTH-1:0];
         mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         is_mul <= 1'b0;
         opd    <= '0;
         acc    <= '0;
         mq     <= '0;
         cnt    <= '0;
      end else if (accept && long_op) begin
         is_mul <= (alufn == OP_MULU);
         acc    <= '0;
         cnt    <= CW'(WIDTH);
         if (alufn == OP_MULU) begin
            opd <= ra;
            mq  <= rb_or_imm;
         end else begin
            opd <= rb_or_imm;
            mq  <= ra;
         end
      end else if (state == S_RUN) begin
         acc <= acc_nxt;
         mq  <= mq_nxt;
         cnt <= cnt - CW'(1);
      end
   end

   assign busy = (state == S_RUN);
`else
   assign long_op = 1'b0;
   assign busy    = 1'b0;
`endif

   assign done = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = long_op ? S_RUN : S_DONE;
            end
         end
`ifdef ALU_MC_MULDIV_EN
         S_RUN: begin
            if (cnt == CW'(1)) begin
               state_nxt = S_DONE;
            end
         end
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Results are loaded on the edge that enters DONE, so they are valid while
   // done is high and then hold until the next completed operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         aluout <= '0;
         hi     <= '0;
         zero   <= 1'b1;
      end else begin
         state <= state_nxt;
         if (accept && !long_op) begin
            aluout <= res_lo;
            hi     <= res_hi;
            zero   <= (res_lo == '0);
         end
`ifdef ALU_MC_MULDIV_EN
         else if (run_last) begin
            aluout <= mq_nxt;
            hi     <= acc_nxt;
            zero   <= (mq_nxt == '0);
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_MULU = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  alufn;
   logic [31:0] ra;
   logic [31:0] rb_or_imm;
   logic [31:0] aluout;
   logic [31:0] hi;
   logic        zero;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .alufn     (alufn),
      .ra        (ra),
      .rb_or_imm (rb_or_imm),
      .aluout    (aluout),
      .hi        (hi),
      .zero      (zero),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Present an op for one rising edge; returns at the negedge of the cycle after accept.
   // Operands are scrambled afterwards to show the DUT does not depend on them.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; alufn = op; ra = a; rb_or_imm = b;
      @(negedge clk);
      start = 1'b0; alufn = 4'hF; ra = 32'hDEAD_BEEF; rb_or_imm = 32'h1234_5678;
   endtask

   // Counts cycles from accept (1 = first cycle after accept) until done, bounded.
   task automatic wait_done(output int cyc, output int nbusy, output bit both);
      cyc = 1; nbusy = 0; both = 1'b0;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
         cyc++;
      end
      if (busy === 1'b1 && done === 1'b1) both = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; alufn = 4'd0; ra = '0; rb_or_imm = '0;
      repeat (2) @(negedge clk);
      n_tests++; if (aluout !== 32'd0) begin n_fail++; $display("FAIL rst_aluout: got %h want %h", aluout, 32'd0); end
      n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_hi: got %h want %h", hi, 32'd0); end
      n_tests++; if (zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero: got %b want 1", zero); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      reset = 1'b0;
   endtask

   task automatic test_add_sub();
      int cyc; int nb; bit both;
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL add_lat: got %0d want 1", cyc); end
      n_tests++; if (aluout !== 32'd0) begin n_fail++; $display("FAIL add_wrap: got %h want %h", aluout, 32'd0); end
      n_tests++; if (zero !== 1'b1) begin n_fail++; $display("FAIL add_zero: got %b want 1", zero); end
      n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL add_hi: got %h want 0", hi); end
      @(negedge clk);
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
      issue(OP_SUB, 32'd5, 32'd7);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL sub_lat: got %0d want 1", cyc); end
      n_tests++; if (aluout !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_res: got %h want %h", aluout, 32'hFFFF_FFFE); end
      n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sub_zero: got %b want 0", zero); end
   endtask

   task automatic test_logic();
      int cyc; int nb; bit both;
      logic [3:0]  ops [0:7];
      logic [31:0] as  [0:7];
      logic [31:0] bs  [0:7];
      logic [31:0] exp [0:7];
      ops[0] = OP_SLT;  as[0] = 32'h8000_0000; bs[0] = 32'd1;         exp[0] = 32'd1;
      ops[1] = OP_SLTU; as[1] = 32'h8000_0000; bs[1] = 32'd1;         exp[1] = 32'd0;
      ops[2] = OP_NOR;  as[2] = 32'd0;         bs[2] = 32'd0;         exp[2] = 32'hFFFF_FFFF;
      ops[3] = OP_AND;  as[3] = 32'hF0F0_1234; bs[3] = 32'h0FF0_FF00; exp[3] = 32'h00F0_1200;
      ops[4] = OP_OR;   as[4] = 32'hF000_0001; bs[4] = 32'h0000_0F00; exp[4] = 32'hF000_0F01;
      ops[5] = OP_XOR;  as[5] = 32'hAAAA_5555; bs[5] = 32'hFFFF_0000; exp[5] = 32'h5555_5555;
      ops[6] = 4'd12;   as[6] = 32'd40;        bs[6] = 32'd2;         exp[6] = 32'd42;
      ops[7] = OP_SLT;  as[7] = 32'd3;         bs[7] = 32'hFFFF_FFFF; exp[7] = 32'd0;
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(cyc, nb, both);
         n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL logic%0d_lat: got %0d want 1", i, cyc); end
         n_tests++; if (aluout !== exp[i]) begin n_fail++; $display("FAIL logic%0d_res: got %h want %h", i, aluout, exp[i]); end
         n_tests++; if (zero !== (exp[i] == 32'd0)) begin n_fail++; $display("FAIL logic%0d_zero: got %b want %b", i, zero, (exp[i] == 32'd0)); end
      end
   endtask

`ifdef ALU_MC_MULDIV_EN
   task automatic test_mulu();
      int cyc; int nb; bit both;
      issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL mul_lat: got %0d want 33", cyc); end
      n_tests++; if (nb !== 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", nb); end
      n_tests++; if (both !== 1'b0) begin n_fail++; $display("FAIL mul_busy_done_overlap: got %b want 0", both); end
      n_tests++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
      n_tests++; if (aluout !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_lo: got %h want %h", aluout, 32'h1); end
      n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL mul_zero: got %b want 0", zero); end
      repeat (3) @(negedge clk);
      n_tests++; if (aluout !== 32'h0000_0001 || hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_hold: got %h:%h want fffffffe:00000001", hi, aluout); end
      issue(OP_MULU, 32'd1234, 32'd5678);
      wait_done(cyc, nb, both);
      n_tests++; if (aluout !== 32'd7006652 || hi !== 32'd0) begin n_fail++; $display("FAIL mul_small: got %h:%h want 0:%h", hi, aluout, 32'd7006652); end
   endtask

   task automatic test_divu();
      int cyc; int nb; bit both;
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div_lat: got %0d want 33", cyc); end
      n_tests++; if (aluout !== 32'd14) begin n_fail++; $display("FAIL div_quo: got %0d want 14", aluout); end
      n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %0d want 2", hi); end
      issue(OP_DIVU, 32'd9, 32'd0);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL div0_lat: got %0d want 1", cyc); end
      n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL div0_busy: got %0d want 0", nb); end
      n_tests++; if (aluout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_quo: got %h want ffffffff", aluout); end
      n_tests++; if (hi !== 32'd9) begin n_fail++; $display("FAIL div0_rem: got %h want 9", hi); end
      issue(OP_DIVU, 32'd5, 32'd9);
      wait_done(cyc, nb, both);
      n_tests++; if (aluout !== 32'd0 || hi !== 32'd5 || zero !== 1'b1) begin n_fail++; $display("FAIL div_small: got q=%h r=%h z=%b want q=0 r=5 z=1", aluout, hi, zero); end
   endtask

   task automatic test_start_ignored();
      int nd = 0; int dc = 0;
      issue(OP_DIVU, 32'd100, 32'd7);
      for (int c = 1; c <= 45; c++) begin
         if (done === 1'b1) begin nd++; dc = c; end
         if (c == 5) begin start = 1'b1; alufn = OP_ADD; ra = 32'd1; rb_or_imm = 32'd1; end
         else start = 1'b0;
         @(negedge clk);
      end
      n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", nd); end
      n_tests++; if (dc !== 33) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want 33", dc); end
      n_tests++; if (aluout !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL ign_result: got q=%0d r=%0d want q=14 r=2", aluout, hi); end
   endtask
`else
   task automatic test_muldiv_disabled();
      int cyc; int nb; bit both;
      issue(OP_MULU, 32'd3, 32'd4);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL nomul_lat: got %0d want 1", cyc); end
      n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL nomul_busy: got %0d want 0", nb); end
      n_tests++; if (aluout !== 32'd0 || hi !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL nomul_res: got %h:%h z=%b want 0:0 z=1", hi, aluout, zero); end
      issue(OP_DIVU, 32'd9, 32'd0);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL nodiv_lat: got %0d want 1", cyc); end
      n_tests++; if (aluout !== 32'd0 || hi !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL nodiv_res: got %h:%h z=%b want 0:0 z=1", hi, aluout, zero); end
   endtask
`endif

   task automatic test_back_to_back();
      int cyc; int nb; bit both;
      issue(OP_ADD, 32'd10, 32'd20);
      wait_done(cyc, nb, both);
      n_tests++; if (aluout !== 32'd30) begin n_fail++; $display("FAIL b2b_first: got %0d want 30", aluout); end
      issue(OP_SUB, 32'd7, 32'd7);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL b2b_lat: got %0d want 1", cyc); end
      n_tests++; if (aluout !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL b2b_beq: got %h z=%b want 0 z=1", aluout, zero); end
   endtask

   task automatic test_reset_mid_op();
      int cyc; int nb; bit both;
`ifdef ALU_MC_MULDIV_EN
      issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (5) @(negedge clk);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
`else
      issue(OP_SUB, 32'd5, 32'd7);
`endif
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got busy=%b done=%b want 0 0", busy, done); end
      n_tests++; if (aluout !== 32'd0 || hi !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL rmid_out: got %h:%h z=%b want 0:0 z=1", hi, aluout, zero); end
      reset = 1'b0;
      issue(OP_ADD, 32'd2, 32'd3);
      wait_done(cyc, nb, both);
      n_tests++; if (cyc !== 1 || aluout !== 32'd5) begin n_fail++; $display("FAIL rmid_add: got lat=%0d res=%0d want lat=1 res=5", cyc, aluout); end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
`ifdef ALU_MC_MULDIV_EN
      test_mulu();
      test_divu();
      test_start_ignored();
`else
      test_muldiv_disabled();
`endif
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
